// File: rtl/pwr_seq_pkg.sv
// Shared constants for the ALU power sequencer: state codes, state width and
// default dwell lengths.
package pwr_seq_pkg;

  localparam int STATE_W          = 3;
  localparam int ISO_CYCLES_DEF   = 2;
  localparam int PWRUP_CYCLES_DEF = 4;

  localparam logic [STATE_W-1:0] ST_ACTIVE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SAVE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_ISO     = 3'd3;
  localparam logic [STATE_W-1:0] ST_OFF     = 3'd4;
  localparam logic [STATE_W-1:0] ST_PWRUP   = 3'd5;
  localparam logic [STATE_W-1:0] ST_RESTORE = 3'd6;
  localparam logic [STATE_W-1:0] ST_DEISO   = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    ACTIVE  = ST_ACTIVE,
    DRAIN   = ST_DRAIN,
    SAVE    = ST_SAVE,
    ISO     = ST_ISO,
    OFF     = ST_OFF,
    PWRUP   = ST_PWRUP,
    RESTORE = ST_RESTORE,
    DEISO   = ST_DEISO
  } pwr_state_e;

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable down-counter used to time the ISO and PWRUP dwells. Loading N gives
// N+1 cycles before done is seen, so callers load (cycles - 1).
module pwr_seq_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/alu_pwr_seq.sv
// Power-sequencing controller for the gated ALU: turns sleep/wake pulses into
// drain/save/isolate/off and on/restore/de-isolate sequences, and blocks the
// ALU start strobe whenever the ALU is not fully active.
//
// state   | meaning
// ACTIVE  | ALU powered, starts pass through
// DRAIN   | waiting for alu_busy to drop
// SAVE    | one-cycle retention save pulse
// ISO     | outputs isolated, ISO_CYCLES before power removal
// OFF     | power removed, waiting for wake
// PWRUP   | power ramp, PWRUP_CYCLES before restore
// RESTORE | one-cycle retention restore pulse (still isolated)
// DEISO   | isolation released, one cycle before starts are allowed
module alu_pwr_seq
  import pwr_seq_pkg::*;
#(
  parameter int ISO_CYCLES   = ISO_CYCLES_DEF,
  parameter int PWRUP_CYCLES = PWRUP_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sleep_req,
  input  logic               wake_req,
  input  logic               alu_busy,
  input  logic               start_in,
  output logic               start_out,
  output logic               alu_pwr_en,
  output logic               iso_en,
  output logic               save,
  output logic               restore,
  output logic [STATE_W-1:0] pwr_state,
  output logic               sleep_ack,
  output logic               wake_ack
);

  localparam int MAX_CYC = (ISO_CYCLES > PWRUP_CYCLES) ? ISO_CYCLES : PWRUP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] ISO_LOAD   = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWRUP_CYCLES - 1);

  pwr_state_e state_q, state_d;
  logic wake_pend_q, wake_pend_d;
  logic sleep_pend_q, sleep_pend_d;
  logic alu_pwr_en_q, alu_pwr_en_d;
  logic iso_en_q, iso_en_d;
  logic save_q, save_d;
  logic restore_q, restore_d;
  logic sleep_ack_q, sleep_ack_d;
  logic wake_ack_q, wake_ack_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  pwr_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next state, pending-request flags and output decode of the next state so
  // the registered outputs line up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    wake_pend_d  = wake_pend_q;
    sleep_pend_d = sleep_pend_q;

    if (wake_req && (state_q inside {DRAIN, SAVE, ISO})) begin
      wake_pend_d = 1'b1;
    end
    if (sleep_req && (state_q inside {PWRUP, RESTORE, DEISO})) begin
      sleep_pend_d = 1'b1;
    end

    case (state_q)
      ACTIVE: begin
        if ((sleep_req && !wake_req) || sleep_pend_q) begin
          state_d      = DRAIN;
          sleep_pend_d = 1'b0;
        end
      end
      DRAIN:   if (!alu_busy) state_d = SAVE;
      SAVE:    state_d = ISO;
      ISO:     if (tmr_done) state_d = OFF;
      OFF: begin
        if (wake_req || wake_pend_q) begin
          state_d     = PWRUP;
          wake_pend_d = 1'b0;
        end
      end
      PWRUP:   if (tmr_done) state_d = RESTORE;
      RESTORE: state_d = DEISO;
      DEISO:   state_d = ACTIVE;
      default: state_d = ACTIVE;
    endcase

    tmr_load = (state_d != state_q) && (state_d inside {ISO, PWRUP});
    tmr_val  = (state_d == ISO) ? ISO_LOAD : PWRUP_LOAD;

    alu_pwr_en_d = (state_d != OFF);
    iso_en_d     = (state_d inside {ISO, OFF, PWRUP, RESTORE});
    save_d       = (state_d == SAVE);
    restore_d    = (state_d == RESTORE);
    sleep_ack_d  = (state_d == OFF) && (state_q != OFF);
    wake_ack_d   = (state_d == ACTIVE) && (state_q == DEISO);
  end

  // State, pends and registered outputs; reset means full power, no isolation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACTIVE;
      wake_pend_q  <= 1'b0;
      sleep_pend_q <= 1'b0;
      alu_pwr_en_q <= 1'b1;
      iso_en_q     <= 1'b0;
      save_q       <= 1'b0;
      restore_q    <= 1'b0;
      sleep_ack_q  <= 1'b0;
      wake_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wake_pend_q  <= wake_pend_d;
      sleep_pend_q <= sleep_pend_d;
      alu_pwr_en_q <= alu_pwr_en_d;
      iso_en_q     <= iso_en_d;
      save_q       <= save_d;
      restore_q    <= restore_d;
      sleep_ack_q  <= sleep_ack_d;
      wake_ack_q   <= wake_ack_d;
    end
  end

  assign start_out  = start_in && (state_q == ACTIVE);
  assign alu_pwr_en = alu_pwr_en_q;
  assign iso_en     = iso_en_q;
  assign save       = save_q;
  assign restore    = restore_q;
  assign pwr_state  = state_q;
  assign sleep_ack  = sleep_ack_q;
  assign wake_ack   = wake_ack_q;

endmodule

// File: tb/tb_alu_pwr_seq.sv
// Bench for alu_pwr_seq: three instances (default, 1/1, 7/15 dwell) share the
// same stimulus; each is compared every cycle against a phase/elapsed-cycle
// reference model, plus directed latency checks against the timing tables.
module tb_alu_pwr_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sleep_req, wake_req, alu_busy, start_in;
  logic [2:0] start_out, alu_pwr_en, iso_en, save, restore, sleep_ack, wake_ack;
  logic [2:0] pwr_state [3];

  int n_checks = 0;
  int n_errors = 0;

  int iso_c [3] = '{2, 1, 7};
  int pu_c  [3] = '{4, 1, 15};

  // reference model: phase 0..7, cycles spent in phase, pends, ack pulses
  int m_st [3];
  int m_el [3];
  bit m_wp [3];
  bit m_sp [3];
  bit m_sa [3];
  bit m_wa [3];

  alu_pwr_seq u0 (
    .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .wake_req(wake_req),
    .alu_busy(alu_busy), .start_in(start_in), .start_out(start_out[0]),
    .alu_pwr_en(alu_pwr_en[0]), .iso_en(iso_en[0]), .save(save[0]),
    .restore(restore[0]), .pwr_state(pwr_state[0]), .sleep_ack(sleep_ack[0]),
    .wake_ack(wake_ack[0])
  );

  alu_pwr_seq #(.ISO_CYCLES(1), .PWRUP_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .wake_req(wake_req),
    .alu_busy(alu_busy), .start_in(start_in), .start_out(start_out[1]),
    .alu_pwr_en(alu_pwr_en[1]), .iso_en(iso_en[1]), .save(save[1]),
    .restore(restore[1]), .pwr_state(pwr_state[1]), .sleep_ack(sleep_ack[1]),
    .wake_ack(wake_ack[1])
  );

  alu_pwr_seq #(.ISO_CYCLES(7), .PWRUP_CYCLES(15)) u2 (
    .clk(clk), .rst_n(rst_n), .sleep_req(sleep_req), .wake_req(wake_req),
    .alu_busy(alu_busy), .start_in(start_in), .start_out(start_out[2]),
    .alu_pwr_en(alu_pwr_en[2]), .iso_en(iso_en[2]), .save(save[2]),
    .restore(restore[2]), .pwr_state(pwr_state[2]), .sleep_ack(sleep_ack[2]),
    .wake_ack(wake_ack[2])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_el[i] = 1;
      m_wp[i] = 1'b0; m_sp[i] = 1'b0; m_sa[i] = 1'b0; m_wa[i] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_step(input bit s, input bit w, input bit b);
    for (int i = 0; i < 3; i++) begin
      int nx;
      nx = m_st[i];
      case (m_st[i])
        0: if ((s && !w) || m_sp[i]) nx = 1;
        1: if (!b) nx = 2;
        2: nx = 3;
        3: if (m_el[i] >= iso_c[i]) nx = 4;
        4: if (w || m_wp[i]) nx = 5;
        5: if (m_el[i] >= pu_c[i]) nx = 6;
        6: nx = 7;
        default: nx = 0;
      endcase
      if (w && (m_st[i] inside {1, 2, 3})) m_wp[i] = 1'b1;
      if (m_st[i] == 4 && nx == 5) m_wp[i] = 1'b0;
      if (s && (m_st[i] inside {5, 6, 7})) m_sp[i] = 1'b1;
      if (m_st[i] == 0 && nx == 1) m_sp[i] = 1'b0;
      m_sa[i] = (nx == 4) && (m_st[i] != 4);
      m_wa[i] = (nx == 0) && (m_st[i] == 7);
      m_el[i] = (nx != m_st[i]) ? 1 : m_el[i] + 1;
      m_st[i] = nx;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.pwr_state", i), int'(pwr_state[i]), m_st[i]);
      check($sformatf("u%0d.alu_pwr_en", i), int'(alu_pwr_en[i]), int'(m_st[i] != 4));
      check($sformatf("u%0d.iso_en", i), int'(iso_en[i]), int'(m_st[i] inside {3, 4, 5, 6}));
      check($sformatf("u%0d.save", i), int'(save[i]), int'(m_st[i] == 2));
      check($sformatf("u%0d.restore", i), int'(restore[i]), int'(m_st[i] == 6));
      check($sformatf("u%0d.sleep_ack", i), int'(sleep_ack[i]), int'(m_sa[i]));
      check($sformatf("u%0d.wake_ack", i), int'(wake_ack[i]), int'(m_wa[i]));
    end
  endtask

  // One clock: drive at negedge, check start gate, clock, check registers.
  task automatic step(input bit s, input bit w, input bit b, input bit st);
    sleep_req = s; wake_req = w; alu_busy = b; start_in = st;
    #1;
    for (int i = 0; i < 3; i++)
      check($sformatf("u%0d.start_out", i), int'(start_out[i]), int'(st && m_st[i] == 0));
    @(posedge clk);
    model_step(s, w, b);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_model(input int i, input int code, input int budget);
    int k = 0;
    while (m_st[i] != code && k < budget) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      k++;
    end
    check($sformatf("timeout_u%0d_state%0d", i, code), m_st[i], code);
  endtask

  // Asynchronous reset between clock edges; outputs must change with no edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_u%0d.alu_pwr_en", i), int'(alu_pwr_en[i]), 1);
      check($sformatf("rst_u%0d.iso_en", i), int'(iso_en[i]), 0);
      check($sformatf("rst_u%0d.pwr_state", i), int'(pwr_state[i]), 0);
      check($sformatf("rst_u%0d.save", i), int'(save[i]), 0);
      check($sformatf("rst_u%0d.restore", i), int'(restore[i]), 0);
    end
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f_save [3], f_iso [3], f_off [3], f_ack [3], n_save [3];
    int f_pon [3], f_rst [3], f_isolo [3], f_wack [3];

    rst_n = 1'b0; sleep_req = 1'b0; wake_req = 1'b0; alu_busy = 1'b0; start_in = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    idle(3);

    // Full sleep/wake latency per instance against the timing tables
    for (int i = 0; i < 3; i++) begin
      f_save[i] = -1; f_iso[i] = -1; f_off[i] = -1; f_ack[i] = -1; n_save[i] = 0;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        if (save[i]) n_save[i]++;
        if (save[i] && f_save[i] < 0) f_save[i] = k;
        if (iso_en[i] && f_iso[i] < 0) f_iso[i] = k;
        if (!alu_pwr_en[i] && f_off[i] < 0) f_off[i] = k;
        if (sleep_ack[i] && f_ack[i] < 0) f_ack[i] = k;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lat_u%0d.save_at", i), f_save[i], 2);
      check($sformatf("lat_u%0d.save_count", i), n_save[i], 1);
      check($sformatf("lat_u%0d.iso_rise", i), f_iso[i], 3);
      check($sformatf("lat_u%0d.pwr_off", i), f_off[i], 3 + iso_c[i]);
      check($sformatf("lat_u%0d.sleep_ack", i), f_ack[i], 3 + iso_c[i]);
      f_pon[i] = -1; f_rst[i] = -1; f_isolo[i] = -1; f_wack[i] = -1;
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        if (alu_pwr_en[i] && f_pon[i] < 0) f_pon[i] = k;
        if (restore[i] && f_rst[i] < 0) f_rst[i] = k;
        if (!iso_en[i] && f_isolo[i] < 0) f_isolo[i] = k;
        if (wake_ack[i] && f_wack[i] < 0) f_wack[i] = k;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lat_u%0d.pwr_on", i), f_pon[i], 1);
      check($sformatf("lat_u%0d.restore_at", i), f_rst[i], pu_c[i] + 1);
      check($sformatf("lat_u%0d.iso_fall", i), f_isolo[i], pu_c[i] + 2);
      check($sformatf("lat_u%0d.wake_ack", i), f_wack[i], pu_c[i] + 3);
    end

    // Busy drain: busy held for the request cycle and two more
    for (int i = 0; i < 3; i++) f_save[i] = -1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      step(1'b0, 1'b0, (k <= 3), 1'b0);
      for (int i = 0; i < 3; i++) if (save[i] && f_save[i] < 0) f_save[i] = k;
    end
    for (int i = 0; i < 3; i++) check($sformatf("busy_u%0d.save_at", i), f_save[i], 4);
    idle(20);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(25);

    // Reset asserted mid-ISO, then start passes right after release
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_model(0, 3, 10);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("start_after_reset", int'(start_out[0]), 1);

    // Pending wake during ISO, pending sleep during PWRUP
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_model(0, 3, 10);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    wait_model(0, 4, 10);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("pend_wake_off_one_cycle", int'(pwr_state[0]), 5);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    wait_model(0, 0, 20);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("pend_sleep_active_one_cycle", int'(pwr_state[0]), 1);
    idle(15);
    do_reset();

    // Simultaneous requests, ignored sleep in OFF, start blocked when not ACTIVE
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) check($sformatf("simul_u%0d", i), int'(pwr_state[i]), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) check($sformatf("sleep_in_off_u%0d", i), int'(pwr_state[i]), 4);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
